// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared shift-op encodings, default widths and the S1 pipeline bundle
package proc_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;
    localparam int TAG_W_DEF   = 5;

    typedef logic [1:0] shift_op_t;

    localparam shift_op_t SHIFT_OP_SLL = 2'b00;
    localparam shift_op_t SHIFT_OP_SRA = 2'b01;
    localparam shift_op_t SHIFT_OP_SRL = 2'b10;
    localparam shift_op_t SHIFT_OP_ROL = 2'b11;

    // Request captured into the first pipeline register.
    typedef struct packed {
        shift_op_t              op;
        logic [WIDTH_DEF-1:0]   data;
        logic [SHAMT_W_DEF-1:0] shamt;
        logic [TAG_W_DEF-1:0]   tag;
    } s1_t;

endpackage

// File: rtl/left_shift.sv
// rtl/left_shift.sv - 32-bit five-level barrel left shifter, zero fill
//   A   : operand
//   amt : shift amount 0..31
//   S   : A << amt
module left_shift (
    input  logic [31:0] A,
    output logic [31:0] S,
    input  logic [4:0]  amt
);

    logic [31:0] l16;
    logic [31:0] l8;
    logic [31:0] l4;
    logic [31:0] l2;

    assign l16 = amt[4] ? {A[15:0],   16'b0} : A;
    assign l8  = amt[3] ? {l16[23:0],  8'b0} : l16;
    assign l4  = amt[2] ? {l8[27:0],   4'b0} : l8;
    assign l2  = amt[1] ? {l4[29:0],   2'b0} : l4;
    assign S   = amt[0] ? {l2[30:0],   1'b0} : l2;

endmodule

// File: rtl/right_shift.sv
// rtl/right_shift.sv - 32-bit five-level barrel right shifter, logical or arithmetic
//   A     : operand
//   amt   : shift amount 0..31
//   arith : 1 replicates A[31] into vacated bits, 0 fills with zeros
//   S     : shifted result
module right_shift (
    input  logic [31:0] A,
    output logic [31:0] S,
    input  logic [4:0]  amt,
    input  logic        arith
);

    logic        fill;
    logic [31:0] r16;
    logic [31:0] r8;
    logic [31:0] r4;
    logic [31:0] r2;

    assign fill = arith & A[31];

    assign r16 = amt[4] ? {{16{fill}}, A[31:16]}  : A;
    assign r8  = amt[3] ? {{8{fill}},  r16[31:8]} : r16;
    assign r4  = amt[2] ? {{4{fill}},  r8[31:4]}  : r8;
    assign r2  = amt[1] ? {{2{fill}},  r4[31:2]}  : r4;
    assign S   = amt[0] ? {fill,       r2[31:1]}  : r2;

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage pipelined SLL/SRA/SRL/ROL execute unit with backpressure and flush
//   clock, reset (async, active-high), flush (sync kill of both stages)
//   in_valid/in_ready/in_op/in_data/in_shamt/in_tag : request from issue
//   out_valid/out_ready/out_data/out_tag/out_zero    : registered result to X/M latch
module shift_exec_stage
    import proc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    // The shifters and the S1 bundle are hard-wired to the default widths.
    if (WIDTH != WIDTH_DEF || SHAMT_W != SHAMT_W_DEF || TAG_W != TAG_W_DEF) begin : g_width_check
        $error("shift_exec_stage supports only WIDTH=32, SHAMT_W=5, TAG_W=5");
    end

    s1_t               s1;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_free;
    logic              s1_adv;
    logic              in_fire;

    logic [WIDTH-1:0]   sll_res;
    logic [WIDTH-1:0]   sr_res;
    logic [WIDTH-1:0]   rot_hi;
    logic [SHAMT_W-1:0] rot_amt;
    logic [WIDTH-1:0]   result;

    // Handshake: in_ready never looks at in_valid, only at pipeline state and out_ready.
    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    left_shift u_sll (
        .A   (s1.data),
        .S   (sll_res),
        .amt (s1.shamt)
    );

    // SRA and SRL share one shifter; only the fill bit differs.
    right_shift u_sr (
        .A     (s1.data),
        .S     (sr_res),
        .amt   (s1.shamt),
        .arith (s1.op == SHIFT_OP_SRA)
    );

    // Rotate high part: data >> (32 - n). In 5 bits 32 - n equals -n; the n=0 wrap
    // to 0 would OR the operand onto itself, so that case is muxed out below.
    assign rot_amt = ~s1.shamt + 5'd1;

    right_shift u_rot (
        .A     (s1.data),
        .S     (rot_hi),
        .amt   (rot_amt),
        .arith (1'b0)
    );

    always_comb begin
        result = s1.data;
        case (s1.op)
            SHIFT_OP_SLL: result = sll_res;
            SHIFT_OP_SRA: result = sr_res;
            SHIFT_OP_SRL: result = sr_res;
            SHIFT_OP_ROL: result = (s1.shamt == '0) ? s1.data : (sll_res | rot_hi);
            default:      result = s1.data;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_zero <= 1'b0;
        end else if (flush) begin
            // Kill wins over everything; a result handed off this cycle is already consumed.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= result;
                    out_tag  <= s1.tag;
                    out_zero <= (result == '0);
                end
            end
            // When in_ready is high S1 is either empty or emptying this edge,
            // so it simply takes whatever the input presents.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_fire) begin
                    s1.op    <= in_op;
                    s1.data  <= in_data;
                    s1.shamt <= in_shamt;
                    s1.tag   <= in_tag;
                end
            end
        end
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage pipelined execute-side shift unit: accepts shift ops from decode/issue over valid/ready, computes SLL/SRA/SRL/ROL on 32-bit operands, and presents the result with its destination tag to the X/M latch.
- Wraps the existing 5-level barrel left shifter and a new right-shift counterpart; adds buffering, backpressure and flush so the shifter can sit on a stallable pipeline.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (the shifters are fixed 32-bit).
- SHAMT_W, 5, shift-amount width, equal to log2(WIDTH).
- TAG_W, 5, destination register tag width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline kill (branch mispredict)
- in_valid  in  1  request present
- in_ready  out  1  stage can accept the request this cycle
- in_op  in  2  00 SLL, 01 SRA, 10 SRL, 11 ROL
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount
- in_tag  in  TAG_W  destination register
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_tag  out  TAG_W  destination tag of the result
- out_zero  out  1  out_data == 0

Behaviour:
- Reset (asynchronous): s1_valid=0 and s2_valid=0, so out_valid=0 and in_ready=1. out_data, out_tag and out_zero reset to 0; out_zero resets to 0, not 1.
- S1 register holds op/data/shamt/tag captured from the input. S2 register holds out_data/out_tag/out_zero computed combinationally from S1.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s1_adv.
  - Input fires when in_valid && in_ready.
  - There is no combinational path from in_valid to in_ready. in_ready depends only on state and out_ready.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready stays high. Throughput is 1 per cycle. Two entries can be in flight.
- Stall: while out_valid && !out_ready, the S2 outputs hold stable. S1 holds its value and in_ready drops if S1 is occupied.
- Simultaneous out-fire and in-fire in the same cycle must not lose or duplicate an entry.
- Ops (n = shamt, 0..31):
  - SLL: data << n, zero fill.
  - SRA: data >> n, filled with sign bit data[31].
  - SRL: data >> n, zero fill.
  - ROL: (data << n) | (data >> (32-n)). For n=0 the result is data unchanged; the 32-bit shift term is excluded.
  - n=0 returns data unchanged for every op.
- flush:
  - Has priority over all advance and accept. On the next edge s1_valid=0 and s2_valid=0.
  - An input presented during the flush cycle is dropped, even though in_ready may read 1.
  - A result handed off during the flush cycle (out_valid && out_ready) counts as consumed.
- Reset asserted mid-operation discards all in-flight entries immediately, without waiting for an edge.

Decomposition:
- Shared package (proc_pkg) holds:
  - SHIFT_OP_SLL=2'b00, SHIFT_OP_SRA=2'b01, SHIFT_OP_SRL=2'b10, SHIFT_OP_ROL=2'b11.
  - WIDTH/SHAMT_W defaults.
  - The S1 struct/bundle of {op, data, shamt, tag}.
- Sub-module right_shift(A, S, amt, arith) is needed:
  - Same 16/8/4/2/1 mux-ladder structure as the existing left shifter.
  - Fill bit = arith & A[31].
- ROL is composed from left_shift(data, n) OR right_shift(data, 32-n, arith=0), with the n=0 case muxed out.

Test Plan:
1. Reset then SLL data=0x0000_0001 shamt=31 tag=3, out_ready=1 -> out_valid on the 2nd edge after accept; out_data=0x8000_0000, out_tag=3, out_zero=0.
2. SRA 0x8000_0010 shamt=4 -> 0xF800_0001. SRL of the same operand and shamt -> 0x0800_0001. ROL 0x8000_0001 shamt=1 -> 0x0000_0003. ROL 0x1234_5678 shamt=0 -> 0x1234_5678.
3. Back-to-back 4 requests (tags 1..4, SLL 0x1 by 0,1,2,3) with out_ready=1 -> 4 consecutive out_valid cycles with 0x1, 0x2, 0x4, 0x8 in order.
4. Backpressure: hold out_ready=0 while streaming -> after 2 accepts in_ready=0 and out_data is stable. Release out_ready -> all entries drain in order, none lost or duplicated.
5. flush with 2 entries in flight plus a new in_valid in the same cycle -> next cycle out_valid=0, in_ready=1, and the dropped input never appears at the output.
6. Assert reset asynchronously mid-stream between edges -> out_valid=0, out_data=0 and in_ready=1 immediately. Post-reset SRL 0x0 by 5 -> out_zero=1.
